// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
// Shared definitions for the common-data-bus arbiter and its source FIFOs.
//   cdb_src_e  : identifies which producer owns a CDB broadcast slot.
//   CDB_VAL_W  : width of the result value and branch-target fields.
//   other_src  : returns the opposite source, used for round-robin rotation.
package cdb_arbiter_pkg;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    localparam int unsigned CDB_VAL_W = 32;

    function automatic cdb_src_e other_src(input cdb_src_e src);
        cdb_src_e result;
        case (src)
            CDB_SRC_ALU: result = CDB_SRC_LSB;
            CDB_SRC_LSB: result = CDB_SRC_ALU;
            default:     result = CDB_SRC_ALU;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
// Small synchronous FIFO buffering results from one producer until the
// arbiter grants that producer the CDB.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous empty; overrides push and pop
//   push      : write request, refused when full (full taken from the
//               registered count, even if a pop happens in the same cycle)
//   pop       : read request, ignored when empty
//   wr_data   : entry to write
//   rd_data   : head entry (combinational from storage)
//   full      : count == DEPTH
//   empty     : count == 0
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic full_s;
    logic empty_s;
    logic push_ok_s;
    logic pop_ok_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign push_ok_s = push & ~full_s & ~flush;
    assign pop_ok_s  = pop & ~empty_s & ~flush;

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_s;
    assign empty   = empty_s;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head data is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares one registered CDB broadcast slot between the ALU and the LSB load
// path. Each producer feeds a cdb_fifo; a round-robin arbiter pops one entry
// per cycle into the CDB output registers. ROB_roll flushes both FIFOs.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   rdy                : global ready, low freezes pushes, pops and rr
//   ROB_roll           : synchronous flush of all buffered results
//   ALU_*              : ALU result push interface, ALU_stall = FIFO full
//   LSB_load_*         : load result push interface, LSB_stall = FIFO full
//   CDB_*              : registered broadcast (flag valid for one cycle)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             ROB_roll,
    input  logic             ALU_flag,
    input  logic [IDX_W-1:0] ALU_ROB_idx,
    input  logic [31:0]      ALU_val,
    input  logic             ALU_jump_flag,
    input  logic [31:0]      ALU_jump_PC,
    output logic             ALU_stall,
    input  logic             LSB_load_flag,
    input  logic [IDX_W-1:0] LSB_load_ROB_idx,
    input  logic [31:0]      LSB_load_val,
    output logic             LSB_stall,
    output logic             CDB_flag,
    output logic             CDB_src,
    output logic [IDX_W-1:0] CDB_ROB_idx,
    output logic [31:0]      CDB_val,
    output logic             CDB_jump_flag,
    output logic [31:0]      CDB_jump_PC
);

    // Entry layout: {idx, val, jump_flag, jump_PC}
    localparam int unsigned ENTRY_W = IDX_W + CDB_VAL_W + 1 + CDB_VAL_W;

    logic [ENTRY_W-1:0] alu_wr_s;
    logic [ENTRY_W-1:0] lsb_wr_s;
    logic [ENTRY_W-1:0] alu_rd_s;
    logic [ENTRY_W-1:0] lsb_rd_s;
    logic               alu_full_s;
    logic               lsb_full_s;
    logic               alu_empty_s;
    logic               lsb_empty_s;
    logic               alu_push_s;
    logic               lsb_push_s;
    logic               alu_pop_s;
    logic               lsb_pop_s;

    logic               grant_valid_s;
    cdb_src_e           grant_src_s;
    logic [ENTRY_W-1:0] grant_entry_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [31:0]        grant_val_s;
    logic               grant_jump_flag_s;
    logic [31:0]        grant_jump_pc_s;

    cdb_src_e           rr_r;
    logic               cdb_flag_r;
    cdb_src_e           cdb_src_r;
    logic [IDX_W-1:0]   cdb_idx_r;
    logic [31:0]        cdb_val_r;
    logic               cdb_jump_flag_r;
    logic [31:0]        cdb_jump_pc_r;

    // Loads never carry branch information, so their jump fields are zero.
    assign alu_wr_s   = {ALU_ROB_idx, ALU_val, ALU_jump_flag, ALU_jump_PC};
    assign lsb_wr_s   = {LSB_load_ROB_idx, LSB_load_val, 1'b0, 32'h0000_0000};
    assign alu_push_s = ALU_flag & rdy & ~ROB_roll;
    assign lsb_push_s = LSB_load_flag & rdy & ~ROB_roll;
    assign alu_pop_s  = grant_valid_s & (grant_src_s == CDB_SRC_ALU);
    assign lsb_pop_s  = grant_valid_s & (grant_src_s == CDB_SRC_LSB);

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (ROB_roll),
        .push    (alu_push_s),
        .pop     (alu_pop_s),
        .wr_data (alu_wr_s),
        .rd_data (alu_rd_s),
        .full    (alu_full_s),
        .empty   (alu_empty_s)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsb_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (ROB_roll),
        .push    (lsb_push_s),
        .pop     (lsb_pop_s),
        .wr_data (lsb_wr_s),
        .rd_data (lsb_rd_s),
        .full    (lsb_full_s),
        .empty   (lsb_empty_s)
    );

    // Grant selection: rr breaks the tie only when both FIFOs hold data.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_src_s   = CDB_SRC_ALU;
        if (rdy && !ROB_roll) begin
            if (!alu_empty_s && !lsb_empty_s) begin
                grant_valid_s = 1'b1;
                grant_src_s   = rr_r;
            end else if (!alu_empty_s) begin
                grant_valid_s = 1'b1;
                grant_src_s   = CDB_SRC_ALU;
            end else if (!lsb_empty_s) begin
                grant_valid_s = 1'b1;
                grant_src_s   = CDB_SRC_LSB;
            end else begin
                grant_valid_s = 1'b0;
                grant_src_s   = CDB_SRC_ALU;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_src_s   = CDB_SRC_ALU;
        end
    end

    // Head entry of the granted source, split into its fields.
    always_comb begin
        grant_entry_s = alu_rd_s;
        case (grant_src_s)
            CDB_SRC_ALU: grant_entry_s = alu_rd_s;
            CDB_SRC_LSB: grant_entry_s = lsb_rd_s;
            default:     grant_entry_s = alu_rd_s;
        endcase
        {grant_idx_s, grant_val_s, grant_jump_flag_s, grant_jump_pc_s} = grant_entry_s;
    end

    // CDB output registers and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r            <= CDB_SRC_ALU;
            cdb_flag_r      <= 1'b0;
            cdb_src_r       <= CDB_SRC_ALU;
            cdb_idx_r       <= IDX_W'(0);
            cdb_val_r       <= 32'h0000_0000;
            cdb_jump_flag_r <= 1'b0;
            cdb_jump_pc_r   <= 32'h0000_0000;
        end else if (ROB_roll) begin
            rr_r       <= CDB_SRC_ALU;
            cdb_flag_r <= 1'b0;
        end else if (grant_valid_s) begin
            rr_r            <= other_src(grant_src_s);
            cdb_flag_r      <= 1'b1;
            cdb_src_r       <= grant_src_s;
            cdb_idx_r       <= grant_idx_s;
            cdb_val_r       <= grant_val_s;
            cdb_jump_flag_r <= grant_jump_flag_s;
            cdb_jump_pc_r   <= grant_jump_pc_s;
        end else begin
            // Covers both rdy low and nothing to send; payload holds.
            cdb_flag_r <= 1'b0;
        end
    end

    assign ALU_stall     = alu_full_s;
    assign LSB_stall     = lsb_full_s;
    assign CDB_flag      = cdb_flag_r;
    assign CDB_src       = cdb_src_r;
    assign CDB_ROB_idx   = cdb_idx_r;
    assign CDB_val       = cdb_val_r;
    assign CDB_jump_flag = cdb_jump_flag_r;
    assign CDB_jump_PC   = cdb_jump_pc_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Directed self-checking bench for cdb_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ROB_roll;
    logic        ALU_flag;
    logic [3:0]  ALU_ROB_idx;
    logic [31:0] ALU_val;
    logic        ALU_jump_flag;
    logic [31:0] ALU_jump_PC;
    logic        ALU_stall;
    logic        LSB_load_flag;
    logic [3:0]  LSB_load_ROB_idx;
    logic [31:0] LSB_load_val;
    logic        LSB_stall;
    logic        CDB_flag;
    logic        CDB_src;
    logic [3:0]  CDB_ROB_idx;
    logic [31:0] CDB_val;
    logic        CDB_jump_flag;
    logic [31:0] CDB_jump_PC;

    int checks;
    int failures;

    cdb_arbiter #(.DEPTH(4), .IDX_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .ROB_roll         (ROB_roll),
        .ALU_flag         (ALU_flag),
        .ALU_ROB_idx      (ALU_ROB_idx),
        .ALU_val          (ALU_val),
        .ALU_jump_flag    (ALU_jump_flag),
        .ALU_jump_PC      (ALU_jump_PC),
        .ALU_stall        (ALU_stall),
        .LSB_load_flag    (LSB_load_flag),
        .LSB_load_ROB_idx (LSB_load_ROB_idx),
        .LSB_load_val     (LSB_load_val),
        .LSB_stall        (LSB_stall),
        .CDB_flag         (CDB_flag),
        .CDB_src          (CDB_src),
        .CDB_ROB_idx      (CDB_ROB_idx),
        .CDB_val          (CDB_val),
        .CDB_jump_flag    (CDB_jump_flag),
        .CDB_jump_PC      (CDB_jump_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ALU entries carry jump_flag = idx[0] and jump_PC = 0x1000 + idx.
    task automatic cycle(input logic af, input logic [3:0] ai, input logic [31:0] av,
                         input logic lf, input logic [3:0] li, input logic [31:0] lv);
        ALU_flag         = af;
        ALU_ROB_idx      = ai;
        ALU_val          = av;
        ALU_jump_flag    = ai[0];
        ALU_jump_PC      = 32'h0000_1000 + {28'h0, ai};
        LSB_load_flag    = lf;
        LSB_load_ROB_idx = li;
        LSB_load_val     = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic check_cdb(input string tag, input logic ef, input logic es,
                             input logic [3:0] ei, input logic [31:0] ev);
        logic        ejf;
        logic [31:0] ejpc;
        ejf  = es ? 1'b0 : ei[0];
        ejpc = es ? 32'h0 : (32'h0000_1000 + {28'h0, ei});
        check({tag, ".flag"}, CDB_flag, ef);
        if (ef) begin
            check({tag, ".src"}, CDB_src, es);
            check({tag, ".idx"}, CDB_ROB_idx, ei);
            check({tag, ".val"}, CDB_val, ev);
            check({tag, ".jf"}, CDB_jump_flag, ejf);
            check({tag, ".jpc"}, CDB_jump_PC, ejpc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".flag"}, CDB_flag, 1'b0);
        check({tag, ".src"}, CDB_src, 1'b0);
        check({tag, ".idx"}, CDB_ROB_idx, 4'h0);
        check({tag, ".val"}, CDB_val, 32'h0);
        check({tag, ".jf"}, CDB_jump_flag, 1'b0);
        check({tag, ".jpc"}, CDB_jump_PC, 32'h0);
        check({tag, ".alu_stall"}, ALU_stall, 1'b0);
        check({tag, ".lsb_stall"}, LSB_stall, 1'b0);
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        rdy              = 1'b1;
        ROB_roll         = 1'b0;
        ALU_flag         = 1'b0;
        ALU_ROB_idx      = 4'h0;
        ALU_val          = 32'h0;
        ALU_jump_flag    = 1'b0;
        ALU_jump_PC      = 32'h0;
        LSB_load_flag    = 1'b0;
        LSB_load_ROB_idx = 4'h0;
        LSB_load_val     = 32'h0;
        rst = 1'b1;
        #2;
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic        es;
        logic [3:0]  ei;
        logic [31:0] ev;
        int          k;
        checks   = 0;
        failures = 0;

        // Reset then single ALU push: visible one edge later, then gone.
        do_reset();
        cycle(1'b1, 4'd3, 32'h11, 1'b0, 4'h0, 32'h0);
        check_cdb("s1_e1", 1'b0, 1'b0, 4'h0, 32'h0);
        idle();
        check_cdb("s1_e2", 1'b1, 1'b0, 4'd3, 32'h11);
        idle();
        check_cdb("s1_e3", 1'b0, 1'b0, 4'h0, 32'h0);
        check("s1_e3.idx_hold", CDB_ROB_idx, 4'd3);

        // Simultaneous arrival from reset: ALU first, then LSB, rr back to ALU.
        do_reset();
        cycle(1'b1, 4'd1, 32'h21, 1'b1, 4'd2, 32'h22);
        check_cdb("s2_e1", 1'b0, 1'b0, 4'h0, 32'h0);
        idle();
        check_cdb("s2_e2", 1'b1, 1'b0, 4'd1, 32'h21);
        idle();
        check_cdb("s2_e3", 1'b1, 1'b1, 4'd2, 32'h22);
        idle();
        check_cdb("s2_e4", 1'b0, 1'b0, 4'h0, 32'h0);
        cycle(1'b1, 4'd5, 32'h25, 1'b1, 4'd6, 32'h26);
        idle();
        check_cdb("s2_rr_a", 1'b1, 1'b0, 4'd5, 32'h25);
        idle();
        check_cdb("s2_rr_b", 1'b1, 1'b1, 4'd6, 32'h26);

        // Fill LSB: both push each cycle, LSB fills after the 6th edge, its
        // 7th push is refused; the stream alternates A0 L0 A1 L1 ... A5 L5.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cycle(c < 6, 4'(c), 32'hA0 + 32'(c), c < 7, 4'(8 + c), 32'hB0 + 32'(c));
            if (c >= 1 && c <= 12) begin
                k  = c - 1;
                es = k[0];
                ei = es ? 4'(8 + k / 2) : 4'(k / 2);
                ev = es ? (32'hB0 + 32'(k / 2)) : (32'hA0 + 32'(k / 2));
                check_cdb($sformatf("s3_c%0d", c), 1'b1, es, ei, ev);
            end else begin
                check_cdb($sformatf("s3_c%0d", c), 1'b0, 1'b0, 4'h0, 32'h0);
            end
            if (c == 4) check("s3_lsb_stall_pre", LSB_stall, 1'b0);
            if (c == 5) begin
                check("s3_lsb_stall_full", LSB_stall, 1'b1);
                check("s3_alu_stall", ALU_stall, 1'b0);
            end
            if (c == 6) check("s3_lsb_stall_drop", LSB_stall, 1'b0);
        end

        // Rollback with entries buffered and rr pointing at LSB.
        do_reset();
        cycle(1'b1, 4'd1, 32'h31, 1'b1, 4'd9, 32'h39);
        cycle(1'b1, 4'd2, 32'h32, 1'b1, 4'd10, 32'h3A);
        check_cdb("s4_pre", 1'b1, 1'b0, 4'd1, 32'h31);
        ROB_roll = 1'b1;
        cycle(1'b1, 4'd3, 32'h33, 1'b1, 4'd11, 32'h3B);
        ROB_roll = 1'b0;
        check_cdb("s4_roll", 1'b0, 1'b0, 4'h0, 32'h0);
        check("s4_alu_stall", ALU_stall, 1'b0);
        check("s4_lsb_stall", LSB_stall, 1'b0);
        for (int c = 0; c < 4; c++) begin
            idle();
            check_cdb($sformatf("s4_quiet%0d", c), 1'b0, 1'b0, 4'h0, 32'h0);
        end
        cycle(1'b1, 4'd4, 32'h34, 1'b1, 4'd12, 32'h3C);
        idle();
        check_cdb("s4_rr_a", 1'b1, 1'b0, 4'd4, 32'h34);
        idle();
        check_cdb("s4_rr_b", 1'b1, 1'b1, 4'd12, 32'h3C);

        // rdy low for 3 cycles mid-stream; order matches A1 L9 A2 L10.
        do_reset();
        cycle(1'b1, 4'd1, 32'h41, 1'b1, 4'd9, 32'h49);
        cycle(1'b1, 4'd2, 32'h42, 1'b1, 4'd10, 32'h4A);
        check_cdb("s5_a1", 1'b1, 1'b0, 4'd1, 32'h41);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 4'd3, 32'h43, 1'b1, 4'd11, 32'h4B);
            check_cdb($sformatf("s5_frozen%0d", c), 1'b0, 1'b0, 4'h0, 32'h0);
        end
        rdy = 1'b1;
        idle();
        check_cdb("s5_l9", 1'b1, 1'b1, 4'd9, 32'h49);
        idle();
        check_cdb("s5_a2", 1'b1, 1'b0, 4'd2, 32'h42);
        idle();
        check_cdb("s5_l10", 1'b1, 1'b1, 4'd10, 32'h4A);
        idle();
        check_cdb("s5_end", 1'b0, 1'b0, 4'h0, 32'h0);

        // Asynchronous reset while a broadcast is live and an entry is queued.
        do_reset();
        cycle(1'b1, 4'd5, 32'h55, 1'b0, 4'h0, 32'h0);
        cycle(1'b1, 4'd6, 32'h56, 1'b0, 4'h0, 32'h0);
        check_cdb("s6_live", 1'b1, 1'b0, 4'd5, 32'h55);
        ALU_flag = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("s6_async");
        rst = 1'b0;
        #1;
        idle();
        check_cdb("s6_after1", 1'b0, 1'b0, 4'h0, 32'h0);
        idle();
        check_cdb("s6_after2", 1'b0, 1'b0, 4'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
